cache: RTL and testbench
========================

// Module: cache
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the cpu load/store path and data_memory.
//  8 blocks x 4 bytes. Byte-wide interface to the cpu; 32-bit block interface to memory.
//  Stalls the cpu through BUSYWAIT on any miss. Refills/evicts whole blocks via a BUSYWAIT handshake with memory.
// PARAMETERS
//  None. Geometry is fixed.
//  ADDRESS split: tag = ADDRESS[7:5], index = ADDRESS[4:2], offset = ADDRESS[1:0].
// PORTS
//  CLK            in   1   clock; all state updates on posedge
//  RESET_MEM      in   1   asynchronous, active-low reset
//  BUSYWAIT       out  1   stall request to the cpu
//  READ           in   1   cpu load request
//  WRITE          in   1   cpu store request
//  WRITEDATA      in   8   store byte
//  READDATA       out  8   load byte
//  ADDRESS        in   8   cpu byte address
//  MEM_BUSYWAIT   in   1   memory busy; low means the transfer is complete
//  MEM_READ       out  1   block read request to memory
//  MEM_WRITE      out  1   block write request to memory
//  MEM_WRITEDATA  out  32  evicted block; byte0 = [7:0]
//  MEM_READDATA   in   32  refill block; byte0 = [7:0]
//  MEM_ADDRESS    out  6   block address = {tag, index}
// BEHAVIOUR
//  - Per-block storage: valid, dirty, tag[2:0], data[31:0]. Byte k of a block is data[8k+7:8k].
//  - hit = valid[index] && (tag_store[index] == tag).
//  - Request = READ | WRITE. If both are high, the access is treated as a write. The cpu holds the request until BUSYWAIT falls.
//  - BUSYWAIT (combinational) = request && (!hit || state != IDLE). It is low when there is no request.
//  - Read hit: READDATA = selected byte, combinational, with no stall cycle.
//  - READDATA holds its last value when no read hit is present.
//  - Write hit: at posedge, write the byte at offset and set dirty = 1. BUSYWAIT stays low.
//  - FSM states and transitions:
//    - IDLE -> WRITEBACK on a miss with valid && dirty.
//    - IDLE -> ALLOCATE on a miss otherwise.
//    - WRITEBACK: MEM_WRITE = 1, MEM_ADDRESS = {old tag, index}, MEM_WRITEDATA = old block.
//      Go to ALLOCATE at the first posedge with MEM_BUSYWAIT = 0 after the request is issued.
//    - ALLOCATE: MEM_READ = 1, MEM_ADDRESS = {tag, index}.
//      Go to UPDATE at the first posedge with MEM_BUSYWAIT = 0.
//    - UPDATE: at posedge, load data = MEM_READDATA, tag = tag, valid = 1, dirty = 0. Go to IDLE.
//      The pending access then hits. A write hit re-sets dirty at the next posedge.
//  - MEM_READ and MEM_WRITE are never both high. Both are 0 in IDLE and UPDATE.
//  - MEM_ADDRESS and MEM_WRITEDATA are stable for the whole memory request.
//  - Reset (RESET_MEM = 0, asynchronous):
//    - all valid and dirty bits = 0; state = IDLE
//    - MEM_READ = MEM_WRITE = 0, BUSYWAIT = 0, READDATA = 0
//    - any in-flight memory transfer is abandoned; data and tag arrays are don't-care
//  - On deassertion, operation starts at the next posedge.
// STRUCTURE
//  - Shared package cache_pkg:
//    - state enum {IDLE, WRITEBACK, ALLOCATE, UPDATE}
//    - TAG_W = 3, IDX_W = 3, OFF_W = 2, NUM_BLOCKS = 8, BLOCK_W = 32
//  - One sub-module, cache_ctrl: the FSM plus the MEM_* and BUSYWAIT drivers.
//  - Arrays, hit logic and byte select stay in the top level.
// TESTING
//  1. Reset -> BUSYWAIT = 0, MEM_READ = MEM_WRITE = 0. A READ of 0x05 then misses (not hit).
//  2. READ 0x05 cold -> ALLOCATE with MEM_ADDRESS = 0x01. Memory returns 0xDDCCBBAA
//     -> READDATA = 0xBB; BUSYWAIT falls the cycle after UPDATE.
//  3. READ 0x06 right after test 2 -> hit: READDATA = 0xCC, BUSYWAIT never rises, no MEM_* activity.
//  4. WRITE 0x5A to 0x04 -> hit, no stall. Block becomes 0xDDCCBB5A and dirty = 1.
//  5. READ 0x24 (tag 1, index 1) -> WRITEBACK: MEM_ADDRESS = 0x01, MEM_WRITEDATA = 0xDDCCBB5A.
//     Then ALLOCATE with MEM_ADDRESS = 0x09. Refill 0x44332211 -> READDATA = 0x11.
//  6. Pull RESET_MEM low during ALLOCATE -> MEM_READ drops immediately. Block 1 is invalid; re-read of 0x24 misses.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared geometry, FSM state type and byte-select helper for the data cache
package cache_pkg;

  localparam int TAG_W      = 3;
  localparam int IDX_W      = 3;
  localparam int OFF_W      = 2;
  localparam int NUM_BLOCKS = 8;
  localparam int BLOCK_W    = 32;
  localparam int MEM_ADDR_W = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    UPDATE
  } state_t;

  // Byte k of a block lives at bits [8k+7:8k]
  function automatic logic [7:0] sel_byte(input logic [BLOCK_W-1:0] blk,
                                          input logic [OFF_W-1:0]   off);
    return blk[8*off +: 8];
  endfunction

endpackage

// File: rtl/cache_if.sv
// rtl/cache_if.sv - cpu-side and memory-side signal bundle of the data cache
interface cache_if;
  import cache_pkg::*;

  // cpu side
  logic                  BUSYWAIT;
  logic                  READ;
  logic                  WRITE;
  logic [7:0]            WRITEDATA;
  logic [7:0]            READDATA;
  logic [7:0]            ADDRESS;
  // memory side
  logic                  MEM_BUSYWAIT;
  logic                  MEM_READ;
  logic                  MEM_WRITE;
  logic [BLOCK_W-1:0]    MEM_WRITEDATA;
  logic [BLOCK_W-1:0]    MEM_READDATA;
  logic [MEM_ADDR_W-1:0] MEM_ADDRESS;

  // The cache itself
  modport slave (
    input  READ, WRITE, WRITEDATA, ADDRESS, MEM_BUSYWAIT, MEM_READDATA,
    output BUSYWAIT, READDATA, MEM_READ, MEM_WRITE, MEM_WRITEDATA, MEM_ADDRESS
  );

  // The cpu plus memory environment around the cache
  modport master (
    output READ, WRITE, WRITEDATA, ADDRESS, MEM_BUSYWAIT, MEM_READDATA,
    input  BUSYWAIT, READDATA, MEM_READ, MEM_WRITE, MEM_WRITEDATA, MEM_ADDRESS
  );

endinterface

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - miss-handling FSM driving the block memory handshake and the cpu stall
module cache_ctrl
  import cache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  request_i,
  input  logic                  hit_i,
  input  logic                  dirty_i,       // indexed block is valid and dirty
  input  logic [TAG_W-1:0]      tag_i,
  input  logic [TAG_W-1:0]      old_tag_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [BLOCK_W-1:0]    old_data_i,
  input  logic                  mem_busywait_i,
  output logic                  busywait_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [MEM_ADDR_W-1:0] mem_address_o,
  output logic [BLOCK_W-1:0]    mem_writedata_o,
  output logic                  update_o,
  output logic                  idle_o
);

  state_t state_q, state_d;

  // State register; reset abandons any in-flight transfer
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and memory-side outputs; address and data derive from held cpu address
  always_comb begin
    state_d         = state_q;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_address_o   = {tag_i, idx_i};
    mem_writedata_o = old_data_i;
    update_o        = 1'b0;
    case (state_q)
      IDLE: begin
        if (request_i && !hit_i) state_d = dirty_i ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        mem_write_o   = 1'b1;
        mem_address_o = {old_tag_i, idx_i};
        if (!mem_busywait_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_read_o = 1'b1;
        if (!mem_busywait_i) state_d = UPDATE;
      end
      UPDATE: begin
        update_o = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign idle_o     = (state_q == IDLE);
  // Reset forces the stall low even while the cpu still holds a request
  assign busywait_o = rst_n_i && request_i && (!hit_i || !idle_o);

endmodule

// File: rtl/cache.sv
// rtl/cache.sv - direct-mapped write-back write-allocate data cache, 8 blocks of 4 bytes
module cache
  import cache_pkg::*;
(
  input  logic   CLK,
  input  logic   RESET_MEM,
  cache_if.slave bus
);

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;

  assign tag = bus.ADDRESS[7:5];
  assign idx = bus.ADDRESS[4:2];
  assign off = bus.ADDRESS[1:0];

  logic [NUM_BLOCKS-1:0]              valid_q, valid_d;
  logic [NUM_BLOCKS-1:0]              dirty_q, dirty_d;
  logic [NUM_BLOCKS-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [NUM_BLOCKS-1:0][BLOCK_W-1:0] data_q, data_d;
  logic [7:0]                         readdata_q, readdata_d;

  logic       request, hit, idle, update;
  logic       read_hit, write_hit;
  logic [7:0] hit_byte;

  assign request   = bus.READ | bus.WRITE;
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign hit_byte  = sel_byte(data_q[idx], off);
  // A simultaneous READ and WRITE is a write
  assign read_hit  = bus.READ && !bus.WRITE && hit && idle;
  assign write_hit = bus.WRITE && hit && idle;

  // Load path is combinational on a hit, otherwise the last loaded byte is held
  assign bus.READDATA = read_hit ? hit_byte : readdata_q;

  cache_ctrl u_ctrl (
    .clk_i           (CLK),
    .rst_n_i         (RESET_MEM),
    .request_i       (request),
    .hit_i           (hit),
    .dirty_i         (valid_q[idx] && dirty_q[idx]),
    .tag_i           (tag),
    .old_tag_i       (tag_q[idx]),
    .idx_i           (idx),
    .old_data_i      (data_q[idx]),
    .mem_busywait_i  (bus.MEM_BUSYWAIT),
    .busywait_o      (bus.BUSYWAIT),
    .mem_read_o      (bus.MEM_READ),
    .mem_write_o     (bus.MEM_WRITE),
    .mem_address_o   (bus.MEM_ADDRESS),
    .mem_writedata_o (bus.MEM_WRITEDATA),
    .update_o        (update),
    .idle_o          (idle)
  );

  // Array next state: refill replaces the whole block clean, a write hit patches one byte dirty
  always_comb begin
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    data_d     = data_q;
    readdata_d = readdata_q;
    if (update) begin
      data_d[idx]  = bus.MEM_READDATA;
      tag_d[idx]   = tag;
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (write_hit) begin
      data_d[idx][8*off +: 8] = bus.WRITEDATA;
      dirty_d[idx]            = 1'b1;
    end
    if (read_hit) readdata_d = hit_byte;
  end

  // Status bits and held load byte are cleared by reset
  always_ff @(posedge CLK or negedge RESET_MEM) begin
    if (!RESET_MEM) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      readdata_q <= '0;
    end else begin
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      readdata_q <= readdata_d;
    end
  end

  // Tag and data contents are meaningless until valid, so they carry no reset
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_cache.sv
// tb/tb_cache.sv - directed scoreboard bench for the data cache with a fixed-latency block memory
module tb_cache;
  import cache_pkg::*;

  localparam int LAT = 3;

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } mem_txn_t;

  logic CLK = 1'b0;
  logic RESET_MEM = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] exp_rd[$];
  mem_txn_t   exp_mem[$];

  cache_if bus ();

  cache dut (
    .CLK       (CLK),
    .RESET_MEM (RESET_MEM),
    .bus       (bus)
  );

  always #5 CLK = ~CLK;

  // Block memory model: busy for LAT cycles of a request, then one ready cycle
  int          mem_cnt = 0;
  logic [63:0] mem_wr = '0;
  logic [31:0] mem_arr [64];
  wire         mem_req = bus.MEM_READ | bus.MEM_WRITE;

  function automatic logic [31:0] preload(input logic [5:0] a);
    case (a)
      6'h01:   return 32'hDDCCBBAA;
      6'h09:   return 32'h44332211;
      default: return {4{2'b00, a}};
    endcase
  endfunction

  assign bus.MEM_BUSYWAIT = mem_req && (mem_cnt != LAT);
  assign bus.MEM_READDATA = mem_wr[bus.MEM_ADDRESS] ? mem_arr[bus.MEM_ADDRESS]
                                                    : preload(bus.MEM_ADDRESS);

  always @(posedge CLK) begin
    if (!mem_req || !bus.MEM_BUSYWAIT) mem_cnt <= 0;
    else                               mem_cnt <= mem_cnt + 1;
    if (bus.MEM_WRITE && !bus.MEM_BUSYWAIT) begin
      mem_arr[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
      mem_wr[bus.MEM_ADDRESS]  <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory-side monitor: exclusivity every busy cycle, transfer contents at completion
  always @(negedge CLK) begin
    if (RESET_MEM && mem_req) begin
      chk("mem_one_hot", {31'd0, bus.MEM_READ && bus.MEM_WRITE}, 32'd0);
      if (!bus.MEM_BUSYWAIT) begin
        if (exp_mem.size() == 0) begin
          chk("mem_unexpected", {26'd0, bus.MEM_ADDRESS}, 32'hFFFF_FFFF);
        end else begin
          mem_txn_t t;
          t = exp_mem.pop_front();
          chk("mem_kind", {31'd0, bus.MEM_WRITE}, {31'd0, t.wr});
          chk("mem_addr", {26'd0, bus.MEM_ADDRESS}, {26'd0, t.addr});
          if (t.wr) chk("mem_wdata", bus.MEM_WRITEDATA, t.data);
        end
      end
    end
  end

  // One cpu access held until BUSYWAIT falls, with stall count and load data checked
  task automatic access(input bit rd, input bit wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input int exp_stalls, input string tag);
    int  stalls;
    bit  done;
    logic [7:0] e;
    stalls = 0;
    done   = 1'b0;
    bus.READ      = rd;
    bus.WRITE     = wr;
    bus.ADDRESS   = addr;
    bus.WRITEDATA = wdata;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge CLK);
      if (!bus.BUSYWAIT) done = 1'b1;
      else               stalls++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_stalls"}, stalls, exp_stalls);
    if (exp_stalls == 0) chk({tag, "_mem_idle"}, {31'd0, mem_req}, 32'd0);
    if (rd && !wr) begin
      if (exp_rd.size() == 0) begin
        chk({tag, "_rd_expected"}, 32'd0, 32'd1);
      end else begin
        e = exp_rd.pop_front();
        chk({tag, "_rdata"}, {24'd0, bus.READDATA}, {24'd0, e});
      end
    end
    @(posedge CLK);
    #1;
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus.READ      = 1'b0;
    bus.WRITE     = 1'b0;
    bus.ADDRESS   = 8'h00;
    bus.WRITEDATA = 8'h00;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
    chk("rst_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
    chk("rst_mem_write", {31'd0, bus.MEM_WRITE}, 32'd0);
    chk("rst_readdata", {24'd0, bus.READDATA}, 32'd0);
    @(posedge CLK);
    #1;
    RESET_MEM = 1'b1;

    // Cold read miss: allocate 0x01, then byte 1 of the refill
    exp_mem.push_back('{wr: 1'b0, addr: 6'h01, data: 32'h0});
    exp_rd.push_back(8'hBB);
    access(1'b1, 1'b0, 8'h05, 8'h00, 2 + LAT + 1, "t2_cold");

    // Read hit on the same block
    exp_rd.push_back(8'hCC);
    access(1'b1, 1'b0, 8'h06, 8'h00, 0, "t3_hit");

    // Write hit then read back the patched and untouched bytes
    access(1'b0, 1'b1, 8'h04, 8'h5A, 0, "t4_wr");
    exp_rd.push_back(8'h5A);
    access(1'b1, 1'b0, 8'h04, 8'h00, 0, "t4_rd0");
    exp_rd.push_back(8'hDD);
    access(1'b1, 1'b0, 8'h07, 8'h00, 0, "t4_rd3");

    // Conflict miss on dirty block: write back old block, then refill
    exp_mem.push_back('{wr: 1'b1, addr: 6'h01, data: 32'hDDCCBB5A});
    exp_mem.push_back('{wr: 1'b0, addr: 6'h09, data: 32'h0});
    exp_rd.push_back(8'h11);
    access(1'b1, 1'b0, 8'h24, 8'h00, 2 + 2 * (LAT + 1), "t5_wb");

    // READ and WRITE together act as a write
    access(1'b1, 1'b1, 8'h25, 8'h77, 0, "rw_both");
    exp_rd.push_back(8'h77);
    access(1'b1, 1'b0, 8'h25, 8'h00, 0, "rw_rd");

    // Reset during an allocate of block 2
    bus.READ    = 1'b1;
    bus.ADDRESS = 8'h48;
    seen        = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (bus.MEM_READ) seen = 1'b1;
    end
    chk("t6_alloc_seen", {31'd0, seen}, 32'd1);
    chk("t6_alloc_addr", {26'd0, bus.MEM_ADDRESS}, 32'h12);
    #2;
    RESET_MEM = 1'b0;
    #1;
    chk("t6_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
    chk("t6_mem_write", {31'd0, bus.MEM_WRITE}, 32'd0);
    chk("t6_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
    chk("t6_readdata", {24'd0, bus.READDATA}, 32'd0);
    bus.READ = 1'b0;
    @(posedge CLK);
    #1;
    RESET_MEM = 1'b1;

    // Block 1 was dirty before reset but is now invalid: plain allocate, no writeback
    exp_mem.push_back('{wr: 1'b0, addr: 6'h09, data: 32'h0});
    exp_rd.push_back(8'h11);
    access(1'b1, 1'b0, 8'h24, 8'h00, 2 + LAT + 1, "t6_reread");

    repeat (2) @(posedge CLK);
    chk("end_mem_queue", exp_mem.size(), 32'd0);
    chk("end_rd_queue", exp_rd.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
